// File: rtl/cherry_isa_pkg.sv
// cherry_isa_pkg: instruction slot types, active-bit positions and the issue bundle layout.
package cherry_isa_pkg;
  typedef logic [21:0] dma_instruction;
  typedef logic [4:0]  arithmetic_instruction;
  typedef logic [16:0] regfile_instruction;
  localparam int DMA_ACTIVE   = 21;
  localparam int ARITH_ACTIVE = 4;
  localparam int CACHE_ACTIVE = 16;
  typedef struct packed {
    dma_instruction        dma;
    arithmetic_instruction arith;
    regfile_instruction    cache;
  } instr_bundle;
  localparam int BUNDLE_W = $bits(instr_bundle);
endpackage

// File: rtl/dispatch_bundle_buffer.sv
// dispatch_bundle_buffer: two-entry pointer FIFO holding fetched bundles; head is always presented.
module dispatch_bundle_buffer
  import cherry_isa_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_push,
  input  logic                i_pop,
  input  logic [BUNDLE_W-1:0] i_data,
  output logic [BUNDLE_W-1:0] o_head,
  output logic [1:0]          o_occ
);
  logic [BUNDLE_W-1:0] r_mem [2];
  logic                r_head, r_tail;
  logic [1:0]          r_occ;
  always_ff @(posedge clk)
    if (i_push) r_mem[r_tail] <= i_data;
  always_ff @(posedge clk)
    if (reset) begin
      r_head <= 1'b0;
      r_tail <= 1'b0;
      r_occ  <= 2'd0;
    end else begin
      assert (!(i_push && !i_pop && r_occ == 2'd2));
      assert (!(i_pop && r_occ == 2'd0));
      if (i_push) r_tail <= !r_tail;
      if (i_pop) r_head <= !r_head;
      r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
    end
  assign o_head = r_mem[r_head];
  assign o_occ  = r_occ;
endmodule

// File: rtl/instruction_dispatch.sv
// instruction_dispatch: fetches bundles from the instruction queue and issues active slots in bundle order.
module instruction_dispatch
  import cherry_isa_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_q_empty,
  output logic               o_q_re,
  input  logic [21:0]        i_q_dma_instr,
  input  logic [4:0]         i_q_arith_instr,
  input  logic [16:0]        i_q_cache_instr,
  output logic               o_dma_valid,
  input  logic               i_dma_ready,
  output logic [21:0]        o_dma_instr,
  output logic               o_arith_valid,
  input  logic               i_arith_ready,
  output logic [4:0]         o_arith_instr,
  output logic               o_cache_valid,
  input  logic               i_cache_ready,
  output logic [16:0]        o_cache_instr,
  output logic               o_idle,
  output logic [STALL_W-1:0] o_stall_cycles
);
  instr_bundle        w_head;
  logic [1:0]         w_occ;
  logic               w_has_head, w_retire, w_stall;
  logic               r_inflight, r_done_dma, r_done_arith, r_done_cache;
  logic [STALL_W-1:0] r_stall;
  dispatch_bundle_buffer u_buf (
    .clk    (clk),
    .reset  (reset),
    .i_push (r_inflight),
    .i_pop  (w_retire),
    .i_data ({i_q_dma_instr, i_q_arith_instr, i_q_cache_instr}),
    .o_head (w_head),
    .o_occ  (w_occ)
  );
  assign w_has_head    = w_occ != 2'd0;
  assign o_dma_valid   = w_has_head && w_head.dma[DMA_ACTIVE] && !r_done_dma;
  assign o_arith_valid = w_has_head && w_head.arith[ARITH_ACTIVE] && !r_done_arith;
  assign o_cache_valid = w_has_head && w_head.cache[CACHE_ACTIVE] && !r_done_cache;
  assign o_dma_instr   = o_dma_valid ? w_head.dma : '0;
  assign o_arith_instr = o_arith_valid ? w_head.arith : '0;
  assign o_cache_instr = o_cache_valid ? w_head.cache : '0;
  // A slot still pending blocks retirement unless it fires this cycle.
  assign w_retire = w_has_head && (!o_dma_valid || i_dma_ready) &&
                    (!o_arith_valid || i_arith_ready) && (!o_cache_valid || i_cache_ready);
  assign w_stall  = (o_dma_valid && !i_dma_ready) || (o_arith_valid && !i_arith_ready) ||
                    (o_cache_valid && !i_cache_ready);
  // Credit counts the bundle still in flight from the queue as already occupying an entry.
  assign o_q_re = !reset && !i_q_empty &&
                  (3'(w_occ) + 3'(r_inflight) - 3'(w_retire)) < 3'(DEPTH);
  assign o_idle         = !w_has_head && !r_inflight && i_q_empty;
  assign o_stall_cycles = r_stall;
  always_ff @(posedge clk)
    if (reset) begin
      r_inflight   <= 1'b0;
      r_done_dma   <= 1'b0;
      r_done_arith <= 1'b0;
      r_done_cache <= 1'b0;
      r_stall      <= '0;
    end else begin
      r_inflight   <= o_q_re;
      r_done_dma   <= !w_retire && (r_done_dma || (o_dma_valid && i_dma_ready));
      r_done_arith <= !w_retire && (r_done_arith || (o_arith_valid && i_arith_ready));
      r_done_cache <= !w_retire && (r_done_cache || (o_cache_valid && i_cache_ready));
      if (w_stall && !(&r_stall)) r_stall <= r_stall + 1'b1;
    end
endmodule
